// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator button types and the button sequencer FSM states
package calc_pkg;
  localparam int NumButtons = 20;
  typedef logic [NumButtons-1:0] buttons_t;
  typedef logic [4:0] active_button_t;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_PRESS, SEQ_GAP} seq_state_t;
  function automatic buttons_t key_onehot(input active_button_t k);
    return buttons_t'(1) << k;
  endfunction
endpackage

// File: rtl/key_fifo.sv
// key_fifo: synchronous FIFO of Depth entries of type T with full/empty flags
module key_fifo #(
  parameter int Depth = 4,
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);
  if (Depth == 1) begin : g_reg
    logic r_valid;
    T     r_data;
    // holding register is occupied from a push until the following pop
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) r_valid <= 1'b0;
      else r_valid <= push_i | (r_valid & ~pop_i);
    // payload is only read while occupied, so it needs no reset
    always_ff @(posedge clk_i)
      if (push_i) r_data <= data_i;
    assign data_o  = r_data;
    assign full_o  = r_valid;
    assign empty_o = ~r_valid;
  end else begin : g_ring
    localparam int AW = $clog2(Depth);
    logic [AW:0] r_wptr, r_rptr;
    T            r_mem [Depth];
    // pointers carry one extra wrap bit to tell full from empty
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (push_i) r_wptr <= r_wptr + 1'b1;
        if (pop_i) r_rptr <= r_rptr + 1'b1;
      end
    // storage write; entries are only read between push and pop
    always_ff @(posedge clk_i)
      if (push_i) r_mem[r_wptr[AW-1:0]] <= data_i;
    assign data_o  = r_mem[r_rptr[AW-1:0]];
    assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty_o = r_wptr == r_rptr;
  end
endmodule

// File: rtl/button_sequencer.sv
// button_sequencer: turns queued key codes into timed one-hot presses with release gaps;
// BUTTON_SEQUENCER_FIFO_EN selects a FifoDepth-deep queue, otherwise a single holding register
module button_sequencer
  import calc_pkg::*;
#(
  parameter int HoldCycles = 4,
  parameter int GapCycles  = 4,
  parameter int FifoDepth  = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  active_button_t key_i,
  input  logic           key_valid_i,
  output logic           key_ready_o,
  output buttons_t       buttons_o,
  output logic           busy_o,
  output logic           err_o
);
`ifdef BUTTON_SEQUENCER_FIFO_EN
  localparam int Depth = FifoDepth;
`else
  localparam int Depth = FifoDepth / FifoDepth;
`endif
  localparam int MaxCnt = HoldCycles > GapCycles ? HoldCycles : GapCycles;
  localparam int CW = $clog2(MaxCnt) + 1;

  logic           w_full, w_empty, w_pop, w_accept, w_in_range;
  active_button_t w_head, r_key;
  seq_state_t     r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  buttons_t       r_buttons;
  logic           r_busy, r_err;

  assign w_accept   = key_valid_i && !w_full;
  assign w_in_range = key_i < active_button_t'(NumButtons);

  key_fifo #(.Depth(Depth), .T(active_button_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_accept && w_in_range),
    .data_i  (key_i),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // next state: pop on idle or at the end of a gap whenever a key is waiting
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      SEQ_IDLE: if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = SEQ_PRESS;
        w_cnt_nxt   = CW'(HoldCycles - 1);
      end
      SEQ_PRESS: begin
        w_state_nxt = r_cnt == '0 ? SEQ_GAP : SEQ_PRESS;
        w_cnt_nxt   = r_cnt == '0 ? CW'(GapCycles - 1) : r_cnt - 1'b1;
      end
      SEQ_GAP: if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
      else if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = SEQ_PRESS;
        w_cnt_nxt   = CW'(HoldCycles - 1);
      end else w_state_nxt = SEQ_IDLE;
      default: w_state_nxt = SEQ_IDLE;
    endcase
  end

  // state, countdown and the key currently being pressed
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_state <= SEQ_IDLE;
      r_cnt   <= '0;
      r_key   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_key   <= w_pop ? w_head : r_key;
    end

  // registered outputs, one cycle behind the state so presses start two edges after the handshake
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_buttons <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_buttons <= r_state == SEQ_PRESS ? key_onehot(r_key) : '0;
      r_busy    <= r_state != SEQ_IDLE || !w_empty;
      r_err     <= w_accept && !w_in_range;
    end

  assign key_ready_o = !w_full;
  assign buttons_o   = r_buttons;
  assign busy_o      = r_busy;
  assign err_o       = r_err;
endmodule

// File: tb/tb_button_sequencer.sv
// tb_button_sequencer: directed stimulus against a timestamp-based model of the sequencer
module tb_button_sequencer;
  import calc_pkg::*;
  localparam int H = 4;
  localparam int G = 4;
`ifdef BUTTON_SEQUENCER_FIFO_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           key_valid_i = 1'b0;
  active_button_t key_i = '0;
  logic           key_ready_o, busy_o, err_o;
  buttons_t       buttons_o;

  button_sequencer #(.HoldCycles(H), .GapCycles(G), .FifoDepth(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .key_i       (key_i),
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .buttons_o   (buttons_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // model: a key popped at edge p is pressed after edges p+1..p+H; next pop no earlier than p+H+G
  int          cyc = 0;
  int          q[$];
  int          last_pop = -1000;
  int          cur_key = 0;
  logic [31:0] e_btn = '0;
  logic        e_busy = 1'b0, e_err = 1'b0, e_ready = 1'b1;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_ni) begin
      q.delete();
      last_pop = -1000;
      e_btn = '0; e_busy = 1'b0; e_err = 1'b0; e_ready = 1'b1;
    end else begin
      bit acc, nonempty;
      nonempty = q.size() > 0;
      acc = key_valid_i && q.size() < D;
      e_busy = nonempty || (last_pop <= cyc - 1 && cyc - 1 < last_pop + H + G);
      e_btn = (cyc >= last_pop + 1 && cyc <= last_pop + H) ? (32'd1 << cur_key) : 32'd0;
      e_err = acc && int'(key_i) >= NumButtons;
      if (nonempty && cyc >= last_pop + H + G) begin
        cur_key = q.pop_front();
        last_pop = cyc;
      end
      if (acc && int'(key_i) < NumButtons) q.push_back(int'(key_i));
      e_ready = q.size() < D;
    end
  end

  int       press_k[$];
  int       press_c[$];
  buttons_t prev_btn = '0;

  // compare process plus press monitor, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    if (!rst_ni) begin
      chk("rst_buttons", 32'(buttons_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_ready", 32'(key_ready_o), 1);
    end else begin
      chk("mdl_buttons", 32'(buttons_o), e_btn);
      chk("mdl_busy", 32'(busy_o), 32'(e_busy));
      chk("mdl_err", 32'(err_o), 32'(e_err));
      chk("mdl_ready", 32'(key_ready_o), 32'(e_ready));
      chk("onehot0", 32'($onehot0(buttons_o)), 1);
    end
    if (buttons_o != '0 && prev_btn == '0)
      for (int b = 0; b < NumButtons; b++)
        if (buttons_o[b]) begin
          press_k.push_back(b);
          press_c.push_back(cyc);
        end
    prev_btn = buttons_o;
  end

  task automatic send(input int k, output int stalls, output int acc_cyc);
    logic got;
    key_i = active_button_t'(k);
    key_valid_i = 1'b1;
    stalls = 0;
    acc_cyc = -1;
    for (int n = 0; n < 100; n++) begin
      got = key_ready_o;
      @(negedge clk);
      if (got) begin
        acc_cyc = cyc;
        break;
      end
      stalls++;
    end
    key_valid_i = 1'b0;
    chk("send_handshake", 32'(acc_cyc >= 0), 1);
  endtask

  task automatic wait_idle();
    int n;
    repeat (3) @(negedge clk);
    for (n = 0; n < 300 && busy_o; n++) @(negedge clk);
    chk("idle_timeout", 32'(busy_o), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s, t, np, n1, cnt_err, cnt_busy, cnt_btn;
    int ek[5] = '{1, 2, 5, 7, 9};
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("init_ready", 32'(key_ready_o), 1);
    chk("init_busy", 32'(busy_o), 0);
    chk("init_buttons", 32'(buttons_o), 0);

    np = press_k.size();
    send(3, s, t);
    for (int i = 1; i <= 11; i++) begin
      chk("k3_buttons", 32'(buttons_o), (i >= 3 && i <= 6) ? 32'h8 : 32'h0);
      chk("k3_busy", 32'(busy_o), (i >= 2 && i <= 10) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("k3_press_count", press_k.size() - np, 1);
    if (press_k.size() == np + 1) chk("k3_latency", press_c[np] - t, 2);
    wait_idle();

    np = press_k.size();
    n1 = 0;
    for (int i = 0; i < 4; i++) begin
      send(ek[i], s, t);
      n1 += s;
    end
`ifdef BUTTON_SEQUENCER_FIFO_EN
    chk("burst_stalls", n1, 0);
`else
    chk("burst_stalled", 32'(n1 > 0), 1);
`endif
    send(9, s, t);
    wait_idle();
    chk("burst_press_count", press_k.size() - np, 5);
    if (press_k.size() == np + 5)
      for (int i = 0; i < 5; i++) begin
        chk("burst_key", press_k[np + i], ek[i]);
        if (i > 0) chk("burst_period", press_c[np + i] - press_c[np + i - 1], 8);
      end

    np = press_k.size();
    send(NumButtons, s, t);
    chk("oor_err_pulse", 32'(err_o), 1);
    cnt_err = 0; cnt_busy = 0; cnt_btn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cnt_err += int'(err_o);
      cnt_busy += int'(busy_o);
      cnt_btn += int'(buttons_o != '0);
    end
    chk("oor_err_once", cnt_err, 0);
    chk("oor_busy", cnt_busy, 0);
    chk("oor_buttons", cnt_btn, 0);
    chk("oor_no_press", press_k.size() - np, 0);

    send(3, s, t);
    send(4, s, t);
    key_i = active_button_t'(6);
    key_valid_i = 1'b1;
    for (int i = 0; i < 50 && buttons_o == '0; i++) @(negedge clk);
    chk("mid_press_seen", 32'(buttons_o), 32'h8);
    #2;
    rst_ni = 1'b0;
    key_valid_i = 1'b0;
    #1;
    chk("async_rst_buttons", 32'(buttons_o), 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    np = press_k.size();
    repeat (30) @(negedge clk);
    chk("post_rst_no_press", press_k.size() - np, 0);
    chk("post_rst_ready", 32'(key_ready_o), 1);
    chk("post_rst_busy", 32'(busy_o), 0);

    np = press_k.size();
    send(4, s, t);
    send(6, s, n1);
`ifdef BUTTON_SEQUENCER_FIFO_EN
    chk("k46_stall", s, 0);
`else
    chk("k46_stall", s, 1);
`endif
    wait_idle();
    chk("k46_press_count", press_k.size() - np, 2);
    if (press_k.size() == np + 2) begin
      chk("k46_first", press_k[np], 4);
      chk("k46_second", press_k[np + 1], 6);
      chk("k46_latency", press_c[np] - t, 2);
      chk("k46_period", press_c[np + 1] - press_c[np], 8);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
